mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit: the sequential, parametrised successor to the single-cycle ALU. It executes MIPS-style MULT/MULTU/DIV/DIVU over WIDTH-bit operands and holds the results in HI/LO registers.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.
- Uses a start/busy/done handshake and a 1-bit-per-cycle shift-add / restoring-divide datapath.

Parameters:
WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits; must be >= 4.

Ports:
CLK  in  1  clock, rising-edge
nRST  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
porta  in  WIDTH  multiplicand / dividend, sampled with start
portb  in  WIDTH  multiplier / divisor, sampled with start
flush  in  1  synchronous abort
busy  out  1  high in CALC or FIX
done  out  1  one-cycle pulse; hi/lo valid and updated
divzero  out  1  valid with done; high when DIV/DIVU had portb==0
hi  out  WIDTH  MULT: upper product half; DIV: remainder
lo  out  WIDTH  MULT: lower product half; DIV: quotient

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, divzero=0, hi=0, lo=0, internal counter/accumulators=0.
- A reset assertion mid-operation aborts immediately and clears hi/lo.
- States:
  - IDLE: start=1 captures op/porta/portb and goes to CALC with count=WIDTH.
  - CALC: one iteration per cycle; count decrements; at count==1 go to FIX.
  - FIX: applies sign correction and writes hi/lo; goes to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE, or to CALC if start=1 (back-to-back accept).
- Latency: start sampled at edge E gives done high in the cycle after edge E+WIDTH+1. That is WIDTH+2 cycles, fixed, unless the optional feature is enabled.
- Signed ops: operate on absolute values; abs(MIN) is treated as unsigned 2^(WIDTH-1).
  - MULT: 2*WIDTH-bit product negated when operand signs differ.
  - DIV: quotient negated when signs differ; remainder takes the sign of the dividend.
  - DIV MIN / -1: lo=MIN, hi=0, divzero=0; no trap.
- Divide by zero (op[1]=1, portb==0):
  - Detected at start; skips CALC and goes IDLE -> DONE in one cycle.
  - hi=porta, lo=all ones, divzero=1.
- divzero is held until the next done.
- flush=1 in any state:
  - Next state is IDLE; done is not asserted; hi/lo keep their previous values.
  - flush has priority over start in the same cycle.
- start while busy=1: ignored; no queueing, no error.
- hi/lo change only on the FIX->DONE transition, the divide-by-zero path, or reset. They are stable while busy.
- Multiply iteration: if multiplier LSB, add multiplicand to the upper accumulator half; then shift the {acc, multiplier} pair right by 1 (carry kept in an extra bit).
- Divide iteration: shift {rem, quot} left by 1; trial-subtract the divisor; set the quotient bit if the result is non-negative.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: in a multiply CALC cycle, when the remaining unshifted multiplier bits are all zero, go directly to FIX. The accumulator is realigned by the remaining count (a single barrel shift).
  - Latency becomes variable, minimum 3 cycles (e.g. portb=1 or 0).
  - Results are identical to the full iteration. Divide is unaffected.
- Undefined: fixed WIDTH+2 latency for all non-zero-divisor ops; no early-out logic synthesized.

Test Plan (WIDTH=32):
- MULT porta=0xFFFFFFFD, portb=0x00000007 -> done exactly 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then back-to-back start in the DONE cycle with MULTU 2x3 -> hi=0, lo=6, no idle gap.
- DIV porta=0xFFFFFFF9 (-7), portb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, divzero=0.
- DIVU porta=0x64, portb=0 -> done one cycle after start, divzero=1, hi=0x64, lo=0xFFFFFFFF. A following DIVU 0x64/7 -> lo=0xE, hi=2, divzero=0.
- Flush and start-while-busy:
  - Preload hi/lo via MULTU 5x5, then start DIV 100/3 and assert flush at cycle 10 -> no done, state IDLE, hi=0, lo=25.
  - A start pulse asserted while busy=1 -> ignored.
- Reset mid-op: nRST low asynchronously during CALC -> busy, done, hi, lo read 0 before the next CLK edge. With MDU_EARLY_OUT_EN, MULTU 0x12345678 x 1 -> done at 3 cycles, lo=0x12345678, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and a start/busy/done handshake.
// Optional multiply early-out when MDU_EARLY_OUT_EN is defined; the default build uses fixed latency.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] porta,
    input  logic [WIDTH-1:0] portb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             divzero_q, divzero_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc, mul_mq;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub, div_acc, div_mq;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;
`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0]   rest_mask;
    logic [2*WIDTH-1:0] eo_pair;
`endif

    // Signed ops have op[0]==0; abs(MIN) wraps to MIN, which reads as 2^(WIDTH-1) unsigned.
    assign a_neg = ~op[0] & porta[WIDTH-1];
    assign b_neg = ~op[0] & portb[WIDTH-1];
    assign a_abs = a_neg ? ('0 - porta) : porta;
    assign b_abs = b_neg ? ('0 - portb) : portb;

    assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc = mul_sum[WIDTH:1];
    assign mul_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};

    assign rem_sh  = {acc_q, mq_q[WIDTH-1]};
    assign div_ge  = rem_sh >= {1'b0, opnd_q};
    assign div_sub = rem_sh[WIDTH-1:0] - opnd_q;
    assign div_acc = div_ge ? div_sub : rem_sh[WIDTH-1:0];
    assign div_mq  = {mq_q[WIDTH-2:0], div_ge};

    assign prod     = {acc_q, mq_q};
    assign prod_fix = neg_q ? ('0 - prod) : prod;
    assign quot_fix = neg_q ? ('0 - mq_q) : mq_q;
    assign rem_fix  = rem_neg_q ? ('0 - acc_q) : acc_q;

`ifdef MDU_EARLY_OUT_EN
    // Multiplier bits still waiting in mq after this step occupy its low count-1 bits.
    assign rest_mask = ~({WIDTH{1'b1}} << (count_q - CW'(1)));
    assign eo_pair   = {mul_acc, mul_mq} >> (count_q - CW'(1));
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (!flush && start) begin
                    if (op[1] && (portb == '0)) begin
                        state_d   = DONE;
                        hi_d      = porta;
                        lo_d      = '1;
                        divzero_d = 1'b1;
                    end else begin
                        state_d   = CALC;
                        count_d   = CW'(WIDTH);
                        acc_d     = '0;
                        is_div_d  = op[1];
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        opnd_d    = op[1] ? b_abs : a_abs;
                        mq_d      = op[1] ? a_abs : b_abs;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CW'(1);
                    if (is_div_q) begin
                        acc_d = div_acc;
                        mq_d  = div_mq;
                    end else begin
                        acc_d = mul_acc;
                        mq_d  = mul_mq;
                    end
                    if (count_q == CW'(1))
                        state_d = FIX;
`ifdef MDU_EARLY_OUT_EN
                    if (!is_div_q && ((mul_mq & rest_mask) == '0)) begin
                        state_d = FIX;
                        acc_d   = eo_pair[2*WIDTH-1:WIDTH];
                        mq_d    = eo_pair[WIDTH-1:0];
                    end
`endif
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d   = DONE;
                    divzero_d = 1'b0;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy    = (state_q == CALC) || (state_q == FIX);
    assign done    = (state_q == DONE);
    assign divzero = divzero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32); latency expectations follow MDU_EARLY_OUT_EN.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         CLK;
    logic         nRST;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] porta;
    logic [W-1:0] portb;
    logic         flush;
    logic         busy;
    logic         done;
    logic         divzero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int nvec = 0;
    int nerr = 0;
    int cyc, bcyc, ndone;

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .start  (start),
        .op     (op),
        .porta  (porta),
        .portb  (portb),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .divzero(divzero),
        .hi     (hi),
        .lo     (lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start for one edge, then waits (bounded) for done; cyc counts edges from the accepting one.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int c, output int bc);
        op = o; porta = a; portb = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        c = 1; bc = 0;
        while (done !== 1'b1 && c < 200) begin
            if (busy === 1'b1) bc++;
            @(posedge CLK); #1;
            c++;
        end
    endtask

    initial begin
        nRST = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; porta = '0; portb = '0;
        repeat (3) @(posedge CLK);
        #3 nRST = 1'b1;
        @(posedge CLK); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_divzero", divzero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        // MULT -3 * 7
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, cyc, bcyc);
`ifdef MDU_EARLY_OUT_EN
        check("mult_lat", cyc, 5);
`else
        check("mult_lat", cyc, 34);
        check("mult_busy_cycles", bcyc, 33);
`endif
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mult_divzero", divzero, 0);

        // MULTU max*max, then back-to-back MULTU 2*3 from the DONE cycle
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcyc);
        check("multu_max_done", done, 1);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        run_op(2'b01, 32'd2, 32'd3, cyc, bcyc);
`ifdef MDU_EARLY_OUT_EN
        check("b2b_lat", cyc, 4);
`else
        check("b2b_lat", cyc, 34);
`endif
        check("b2b_hi", hi, 0);
        check("b2b_lo", lo, 6);

        // MULT -5 * 2
        run_op(2'b00, 32'hFFFF_FFFB, 32'd2, cyc, bcyc);
        check("mult_neg2_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg2_lo", lo, 32'hFFFF_FFF6);

        // DIV -7 / 2 and MIN / -1
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bcyc);
        check("div_lat", cyc, 34);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcyc);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 0);
        check("divmin_divzero", divzero, 0);

        // DIVU by zero, then DIVU 100/7
        run_op(2'b11, 32'h64, 32'd0, cyc, bcyc);
        check("div0_lat", cyc, 1);
        check("div0_busy_cycles", bcyc, 0);
        check("div0_divzero", divzero, 1);
        check("div0_hi", hi, 32'h64);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        op = 2'b11; porta = 32'h64; portb = 32'd7; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("divzero_held", divzero, 1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("divu_lat", cyc, 34);
        check("divu_lo", lo, 32'hE);
        check("divu_hi", hi, 2);
        check("divu_divzero", divzero, 0);

        // Preload 25, then flush a DIV 100/3 mid-way
        run_op(2'b01, 32'd5, 32'd5, cyc, bcyc);
        check("preload_lo", lo, 25);
        op = 2'b10; porta = 32'd100; portb = 32'd3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        #1 flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        ndone = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done === 1'b1) ndone++;
        end
        check("flush_no_done", ndone, 0);
        check("flush_hi", hi, 0);
        check("flush_lo", lo, 25);

        // flush wins over start in the same idle cycle
        op = 2'b01; porta = 32'd7; portb = 32'd7; start = 1'b1; flush = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_prio_busy", busy, 0);

        // start pulse while busy is ignored
        op = 2'b01; porta = 32'd3; portb = 32'd4; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1 porta = 32'd9; portb = 32'd9; start = 1'b1;
        check("busy_at_restart", busy, 1);
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 6;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
        end
`ifndef MDU_EARLY_OUT_EN
        check("ignored_start_lat", cyc, 34);
`endif
        check("ignored_start_lo", lo, 12);
        check("ignored_start_hi", hi, 0);
        @(posedge CLK); #1;
        check("ignored_start_idle", busy, 0);

        // asynchronous reset during CALC
        op = 2'b01; porta = 32'd1000; portb = 32'hFFFF; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #3 nRST = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        #2 nRST = 1'b1;
        @(posedge CLK); #1;

        // multiply by one
        run_op(2'b01, 32'h1234_5678, 32'd1, cyc, bcyc);
`ifdef MDU_EARLY_OUT_EN
        check("x1_lat", cyc, 3);
`else
        check("x1_lat", cyc, 34);
`endif
        check("x1_lo", lo, 32'h1234_5678);
        check("x1_hi", hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
